// File: rtl/store_commit_buffer.sv
// ---------------------------------------------------------------------------
// store_commit_buffer
//
// Purpose:
//   Holds committed stores (up to two per cycle from Commit) and writes them
//   to the data-memory port one per cycle, oldest first, over a req/gnt
//   handshake. Also answers load address-hazard queries and supports a
//   full-drain request used by SYNC/cache operations.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_st_valid0/addr0/...   commit slot0 store (older of the pair)
//   i_st_valid1/addr1/...   commit slot1 store (younger of the pair)
//   o_sq_ready              at least two free entries
//   o_mem_req/addr/wdata/be head entry presented to memory
//   i_mem_gnt               memory accepts the head entry this cycle
//   i_q_addr, o_q_hit       load hazard query against pending entries
//   i_drain_req             level request to empty the buffer
//   o_drain_done            one-cycle pulse when the drain completes
//   o_empty                 no pending entries
//   o_overflow              sticky: a store arrived with no room for it
// ---------------------------------------------------------------------------
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_st_valid0,
  input  logic [AW-1:0] i_st_addr0,
  input  logic [31:0]   i_st_data0,
  input  logic [3:0]    i_st_be0,
  input  logic          i_st_valid1,
  input  logic [AW-1:0] i_st_addr1,
  input  logic [31:0]   i_st_data1,
  input  logic [3:0]    i_st_be1,
  output logic          o_sq_ready,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic          i_mem_gnt,
  input  logic [AW-1:0] i_q_addr,
  output logic          o_q_hit,
  input  logic          i_drain_req,
  output logic          o_drain_done,
  output logic          o_empty,
  output logic          o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_ACTIVE,
    DRAIN_DONE
  } drainState_t;

  logic [AW-1:0] r_addrMem [DEPTH];
  logic [31:0]   r_dataMem [DEPTH];
  logic [3:0]    r_beMem   [DEPTH];

  logic [PW-1:0] r_headPtr;
  logic [PW-1:0] r_tailPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  drainState_t   r_drainState;
  logic          r_drainDone;

  logic [CW-1:0] w_free;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_drop;
  logic [CW-1:0] w_nAcc;
  logic          w_deq;
  logic [PW-1:0] w_tailPlus1;
  logic          w_qHit;

  // Room is judged from the registered count only; an entry leaving this
  // cycle does not make space for an arrival in the same cycle. When only
  // one slot fits, slot0 wins because it is the older store.
  assign w_free      = CW'(DEPTH) - r_count;
  assign w_acc0      = i_st_valid0 && (w_free >= CW'(1));
  assign w_acc1      = i_st_valid1 &&
                       (i_st_valid0 ? (w_free >= CW'(2)) : (w_free >= CW'(1)));
  assign w_drop      = (i_st_valid0 && !w_acc0) || (i_st_valid1 && !w_acc1);
  assign w_nAcc      = CW'(w_acc0) + CW'(w_acc1);
  assign w_deq       = o_mem_req && i_mem_gnt;
  assign w_tailPlus1 = r_tailPtr + PW'(1);

  // Storage writes. The array is deliberately not reset: validity is
  // tracked purely by head pointer and count. A lone slot1 store goes
  // into the tail entry, just like a lone slot0 store.
  always_ff @(posedge i_clk) begin
    if (w_acc0) begin
      r_addrMem[r_tailPtr] <= i_st_addr0;
      r_dataMem[r_tailPtr] <= i_st_data0;
      r_beMem[r_tailPtr]   <= i_st_be0;
    end
    if (w_acc1) begin
      if (w_acc0) begin
        r_addrMem[w_tailPlus1] <= i_st_addr1;
        r_dataMem[w_tailPlus1] <= i_st_data1;
        r_beMem[w_tailPlus1]   <= i_st_be1;
      end else begin
        r_addrMem[r_tailPtr] <= i_st_addr1;
        r_dataMem[r_tailPtr] <= i_st_data1;
        r_beMem[r_tailPtr]   <= i_st_be1;
      end
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping. Enqueue and dequeue
  // in the same cycle combine into one count update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_headPtr  <= '0;
      r_tailPtr  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tailPtr <= r_tailPtr + PW'(w_nAcc);
      if (w_deq) begin
        r_headPtr <= r_headPtr + PW'(1);
      end
      r_count <= r_count + w_nAcc - CW'(w_deq);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Drain sequencer: once requested it waits until the buffer is seen empty
  // (stores arriving meanwhile simply extend the wait), then spends exactly
  // one cycle in DONE, which is when drain_done is high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drainState <= DRAIN_IDLE;
      r_drainDone  <= 1'b0;
    end else begin
      r_drainDone <= 1'b0;
      case (r_drainState)
        DRAIN_IDLE: begin
          if (i_drain_req) begin
            r_drainState <= DRAIN_ACTIVE;
          end
        end
        DRAIN_ACTIVE: begin
          if (r_count == '0) begin
            r_drainState <= DRAIN_DONE;
            r_drainDone  <= 1'b1;
          end
        end
        DRAIN_DONE: begin
          r_drainState <= i_drain_req ? DRAIN_ACTIVE : DRAIN_IDLE;
        end
        default: begin
          r_drainState <= DRAIN_IDLE;
        end
      endcase
    end
  end

  // Load hazard check over every pending entry, including the one currently
  // offered to memory. Only the word address is compared, and an entry with
  // no byte enables writes nothing so it can never conflict.
  always_comb begin
    w_qHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if ((r_addrMem[r_headPtr + PW'(i)][AW-1:2] == i_q_addr[AW-1:2]) &&
            (r_beMem[r_headPtr + PW'(i)] != 4'b0000)) begin
          w_qHit = 1'b1;
        end
      end
    end
  end

  assign o_mem_req    = (r_count != '0);
  assign o_mem_addr   = o_mem_req ? {r_addrMem[r_headPtr][AW-1:2], 2'b00} : '0;
  assign o_mem_wdata  = o_mem_req ? r_dataMem[r_headPtr] : 32'h0;
  assign o_mem_be     = o_mem_req ? r_beMem[r_headPtr] : 4'h0;
  assign o_sq_ready   = (w_free >= CW'(2));
  assign o_empty      = (r_count == '0);
  assign o_overflow   = r_overflow;
  assign o_q_hit      = w_qHit;
  assign o_drain_done = r_drainDone;

endmodule

// File: tb/tb_store_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_commit_buffer
//
// Purpose:
//   Drives store_commit_buffer with directed scenarios and then random
//   traffic, comparing every output each cycle against a queue-based model
//   of the buffer kept in this file.
// ---------------------------------------------------------------------------
module tb_store_commit_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        stValid0;
  logic [31:0] stAddr0;
  logic [31:0] stData0;
  logic [3:0]  stBe0;
  logic        stValid1;
  logic [31:0] stAddr1;
  logic [31:0] stData1;
  logic [3:0]  stBe1;
  logic        sqReady;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memGnt;
  logic [31:0] qAddr;
  logic        qHit;
  logic        drainReq;
  logic        drainDone;
  logic        empty;
  logic        overflow;

  int vectors    = 0;
  int miscompares = 0;

  entry_t modelQ[$];
  bit     mOverflow   = 1'b0;
  bit     mDrainWait  = 1'b0;
  bit     mDonePulse  = 1'b0;

  store_commit_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_st_valid0  (stValid0),
    .i_st_addr0   (stAddr0),
    .i_st_data0   (stData0),
    .i_st_be0     (stBe0),
    .i_st_valid1  (stValid1),
    .i_st_addr1   (stAddr1),
    .i_st_data1   (stData1),
    .i_st_be1     (stBe1),
    .o_sq_ready   (sqReady),
    .o_mem_req    (memReq),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_mem_be     (memBe),
    .i_mem_gnt    (memGnt),
    .i_q_addr     (qAddr),
    .o_q_hit      (qHit),
    .i_drain_req  (drainReq),
    .o_drain_done (drainDone),
    .o_empty      (empty),
    .o_overflow   (overflow)
  );

  // Free-running clock; inputs change on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  // Stores are taken oldest-first while room (measured before this edge)
  // remains; anything left over is lost and marks overflow.
  task automatic modelUpdate();
    int room;
    int oldSize;
    bit take0;
    bit take1;
    entry_t e;
    if (rst) begin
      modelQ.delete();
      mOverflow  = 1'b0;
      mDrainWait = 1'b0;
      mDonePulse = 1'b0;
    end else begin
      oldSize = modelQ.size();
      room    = DEPTH - oldSize;
      take0   = stValid0 && (room > 0);
      if (take0) room--;
      take1   = stValid1 && (room > 0);
      if ((stValid0 && !take0) || (stValid1 && !take1)) mOverflow = 1'b1;
      if (mDonePulse) begin
        mDonePulse = 1'b0;
        mDrainWait = drainReq;
      end else if (mDrainWait) begin
        if (oldSize == 0) begin
          mDonePulse = 1'b1;
          mDrainWait = 1'b0;
        end
      end else if (drainReq) begin
        mDrainWait = 1'b1;
      end
      if ((oldSize > 0) && memGnt) void'(modelQ.pop_front());
      if (take0) begin
        e.addr = stAddr0; e.data = stData0; e.be = stBe0;
        modelQ.push_back(e);
      end
      if (take1) begin
        e.addr = stAddr1; e.data = stData1; e.be = stBe1;
        modelQ.push_back(e);
      end
    end
  endtask

  // Compares all outputs against the model state.
  task automatic checkAll();
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [3:0]  expBe;
    bit          expHit;
    expAddr = '0; expData = '0; expBe = '0; expHit = 1'b0;
    if (modelQ.size() > 0) begin
      expAddr = {modelQ[0].addr[31:2], 2'b00};
      expData = modelQ[0].data;
      expBe   = modelQ[0].be;
    end
    foreach (modelQ[i]) begin
      if ((modelQ[i].addr[31:2] == qAddr[31:2]) && (modelQ[i].be != 4'h0))
        expHit = 1'b1;
    end
    checkOutput("mem_req", memReq, modelQ.size() > 0);
    checkOutput("mem_addr", memAddr, expAddr);
    checkOutput("mem_wdata", memWdata, expData);
    checkOutput("mem_be", memBe, expBe);
    checkOutput("sq_ready", sqReady, (DEPTH - modelQ.size()) >= 2);
    checkOutput("empty", empty, modelQ.size() == 0);
    checkOutput("overflow", overflow, mOverflow);
    checkOutput("drain_done", drainDone, mDonePulse);
    checkOutput("q_hit", qHit, expHit);
  endtask

  // One clock: update the model from the present inputs, take the edge,
  // then compare on the following falling edge.
  task automatic stepCycle();
    modelUpdate();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  // Drives one cycle of stimulus (reset deasserted) and steps the clock.
  task automatic applyStimulus(input logic v0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic [3:0] b0,
                               input logic v1, input logic [31:0] a1,
                               input logic [31:0] d1, input logic [3:0] b1,
                               input logic gnt, input logic [31:0] qa,
                               input logic dr);
    rst = 1'b0;
    stValid0 = v0; stAddr0 = a0; stData0 = d0; stBe0 = b0;
    stValid1 = v1; stAddr1 = a1; stData1 = d1; stBe1 = b1;
    memGnt = gnt; qAddr = qa; drainReq = dr;
    stepCycle();
  endtask

  task automatic applyIdle(input logic gnt);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, gnt, '0, 1'b0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    bit allowFire;
    rst = 1'b1;
    stValid0 = 1'b0; stAddr0 = '0; stData0 = '0; stBe0 = '0;
    stValid1 = 1'b0; stAddr1 = '0; stData1 = '0; stBe1 = '0;
    memGnt = 1'b0; qAddr = '0; drainReq = 1'b0;
    applyReset();
    checkOutput("reset_empty", empty, 1'b1);
    checkOutput("reset_sq_ready", sqReady, 1'b1);

    // Dual fire drains back-to-back on consecutive cycles.
    applyStimulus(1'b1, 32'h100, 32'hAABBCCDD, 4'hF,
                  1'b1, 32'h204, 32'h00000011, 4'h1, 1'b1, '0, 1'b0);
    checkOutput("t1_addr0", memAddr, 32'h100);
    checkOutput("t1_data0", memWdata, 32'hAABBCCDD);
    applyIdle(1'b1);
    checkOutput("t1_addr1", memAddr, 32'h204);
    checkOutput("t1_be1", memBe, 4'h1);
    applyIdle(1'b1);
    checkOutput("t1_empty", empty, 1'b1);

    // Lone slot1 store, unaligned address presented word-aligned.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h302, 32'h55, 4'h3,
                  1'b0, '0, 1'b0);
    checkOutput("t2_req", memReq, 1'b1);
    checkOutput("t2_addr", memAddr, 32'h300);
    applyIdle(1'b1);
    checkOutput("t2_empty", empty, 1'b1);

    // Fill to DEPTH-1, then overfill: slot1 is dropped.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h110 + 32'(i * 8), 32'(i), 4'hF,
                    1'b1, 32'h114 + 32'(i * 8), 32'(i + 100), 4'hF,
                    1'b0, '0, 1'b0);
    end
    applyStimulus(1'b1, 32'h170, 32'h7, 4'hF, 1'b0, '0, '0, '0,
                  1'b0, '0, 1'b0);
    checkOutput("t3_sq_ready", sqReady, 1'b0);
    checkOutput("t3_no_ovf", overflow, 1'b0);
    applyStimulus(1'b1, 32'h180, 32'h8, 4'hF, 1'b1, 32'h184, 32'h9, 4'hF,
                  1'b0, '0, 1'b0);
    checkOutput("t3_ovf", overflow, 1'b1);
    for (int i = 0; i < 7; i++) applyIdle(1'b1);
    checkOutput("t3_last_addr", memAddr, 32'h180);
    applyIdle(1'b1);
    checkOutput("t3_empty", empty, 1'b1);
    checkOutput("t3_ovf_sticky", overflow, 1'b1);
    applyReset();
    checkOutput("t3_ovf_cleared", overflow, 1'b0);

    // Enqueue two while dequeuing one.
    applyStimulus(1'b1, 32'h500, 32'h1, 4'hF, 1'b0, '0, '0, '0,
                  1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h504, 32'h2, 4'hF, 1'b1, 32'h508, 32'h3, 4'hF,
                  1'b1, '0, 1'b0);
    checkOutput("t4_head", memAddr, 32'h504);
    checkOutput("t4_no_ovf", overflow, 1'b0);
    applyIdle(1'b1);
    checkOutput("t4_second", memAddr, 32'h508);
    applyIdle(1'b1);
    checkOutput("t4_empty", empty, 1'b1);

    // Hazard query on the word address.
    applyStimulus(1'b1, 32'h400, 32'hDEAD, 4'hF, 1'b0, '0, '0, '0,
                  1'b0, '0, 1'b0);
    qAddr = 32'h402;
    #1 checkOutput("t5_hit", qHit, 1'b1);
    qAddr = 32'h404;
    #1 checkOutput("t5_miss", qHit, 1'b0);
    applyIdle(1'b1);

    // Drain with three pending: exactly one done pulse.
    applyStimulus(1'b1, 32'h600, 32'h1, 4'hF, 1'b1, 32'h604, 32'h2, 4'hF,
                  1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h608, 32'h3, 4'hF, 1'b0, '0, '0, '0,
                  1'b0, '0, 1'b0);
    pulses = 0;
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, '0, 1'b1);
    if (drainDone) pulses++;
    for (int i = 0; i < 8; i++) begin
      applyIdle(1'b1);
      if (drainDone) pulses++;
    end
    checkOutput("t6_pulses", 32'(pulses), 32'd1);

    // Reset while a request is outstanding.
    applyStimulus(1'b1, 32'h700, 32'h1, 4'hF, 1'b1, 32'h704, 32'h2, 4'hF,
                  1'b0, '0, 1'b0);
    checkOutput("t6_req_before", memReq, 1'b1);
    applyReset();
    checkOutput("t6_req_after", memReq, 1'b0);
    checkOutput("t6_empty_after", empty, 1'b1);

    // Random traffic; commit normally honours sq_ready but occasionally
    // ignores it to exercise the drop path.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset();
      end else begin
        allowFire = ((DEPTH - modelQ.size()) >= 2) ||
                    ($urandom_range(0, 99) == 0);
        applyStimulus(allowFire && ($urandom_range(0, 1) == 1),
                      32'h100 + 32'($urandom_range(0, 31)), $urandom,
                      4'($urandom_range(0, 15)),
                      allowFire && ($urandom_range(0, 1) == 1),
                      32'h100 + 32'($urandom_range(0, 31)), $urandom,
                      4'($urandom_range(0, 15)),
                      $urandom_range(0, 1) == 1,
                      32'h100 + 32'($urandom_range(0, 31)),
                      $urandom_range(0, 19) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
